// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Contents:
//   - XLEN_DEF        default datapath width
//   - SIZE_B/H/W/D    access size encodings (byte, half, word, dword)
//   - ADDR_MODE_*     effective-address operand select
//   - size_to_mask()  unshifted byte-enable mask for an access size
package cpu_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;

   localparam logic ADDR_MODE_IMM = 1'b0;
   localparam logic ADDR_MODE_IDX = 1'b1;

   function automatic logic [7:0] size_to_mask(input logic [1:0] size);
      logic [7:0] mask;
      case (size)
         SIZE_B:  mask = 8'h01;
         SIZE_H:  mask = 8'h03;
         SIZE_W:  mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/agu_align.sv
// Address generation and lane alignment (purely combinational).
// Ports:
//   addr_mode  in   0 = rs1+imm, 1 = rs1+rs2
//   size       in   access size (SIZE_B/H/W/D)
//   mem_rd     in   load
//   mem_wr     in   store
//   imm        in   sign-extended immediate
//   rs1        in   base operand
//   rs2        in   index operand / store data
//   ea         out  effective address, wraps modulo 2^XLEN
//   wdata      out  rs2 shifted to the byte lane selected by ea
//   be         out  byte enables, zero for non-memory or bad accesses
//   misalign   out  memory access that is misaligned or illegal
module agu_align
   import cpu_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   localparam int BE_W  = XLEN / 8,
   localparam int OFF_W = $clog2(BE_W)
) (
   input  logic            addr_mode,
   input  logic [1:0]      size,
   input  logic            mem_rd,
   input  logic            mem_wr,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic [XLEN-1:0] ea,
   output logic [XLEN-1:0] wdata,
   output logic [BE_W-1:0] be,
   output logic            misalign
);

   logic [OFF_W-1:0] off;
   logic             aligned;
   logic             is_mem;
   logic             bad;
   logic [BE_W-1:0]  base_mask;

   assign ea  = rs1 + ((addr_mode == ADDR_MODE_IDX) ? rs2 : imm);
   assign off = ea[OFF_W-1:0];

   // A dword is only reachable on a 64-bit datapath; on 32-bit it is illegal.
   always_comb begin
      aligned = 1'b0;
      case (size)
         SIZE_B:  aligned = 1'b1;
         SIZE_H:  aligned = ~ea[0];
         SIZE_W:  aligned = (ea[1:0] == 2'b00);
         default: aligned = (XLEN == 64) && (ea[2:0] == 3'b000);
      endcase
   end

   // Simultaneous load and store is treated the same as a bad alignment.
   assign is_mem   = mem_rd | mem_wr;
   assign bad      = ~aligned | (mem_rd & mem_wr);
   assign misalign = is_mem & bad;

   assign base_mask = BE_W'(size_to_mask(size));
   assign be        = (is_mem && !bad) ? (base_mask << off) : '0;
   assign wdata     = rs2 << {off, 3'b000};

endmodule

// File: rtl/exmem_stage_reg.sv
// EX/MEM pipeline register with valid/ready handshake, stall and flush.
// The effective address, store lanes and byte enables come from agu_align
// and are registered here together with the gated control bits.
// Ports:
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   valid_i / ready_o           upstream handshake (ready_o combinational)
//   flush_i                     drop the held entry and any incoming one
//   wb_i, mem_rd_i, mem_wr_i    instruction control bits
//   addr_mode_i, size_i         address mode and access size
//   alu_res_i, imm_i            ALU result, immediate
//   rs1_data_i, rs2_data_i      base, index / store data
//   rd_addr_i                   destination register
//   valid_o / ready_i           downstream handshake
//   wb_o, mem_rd_o, mem_wr_o    registered control, gated by misalign
//   mem_addr_o, mem_wdata_o     effective address, lane-aligned store data
//   mem_be_o                    byte enables
//   alu_res_o, rd_addr_o        registered ALU result, destination
//   misalign_o                  misaligned or illegal memory access
module exmem_stage_reg
   import cpu_pkg::*;
#(
   parameter  int XLEN    = XLEN_DEF,
   parameter  int RADDR_W = 5,
   localparam int BE_W    = XLEN / 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic               flush_i,
   input  logic               wb_i,
   input  logic               mem_rd_i,
   input  logic               mem_wr_i,
   input  logic               addr_mode_i,
   input  logic [1:0]         size_i,
   input  logic [XLEN-1:0]    alu_res_i,
   input  logic [XLEN-1:0]    imm_i,
   input  logic [XLEN-1:0]    rs1_data_i,
   input  logic [XLEN-1:0]    rs2_data_i,
   input  logic [RADDR_W-1:0] rd_addr_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               wb_o,
   output logic               mem_rd_o,
   output logic               mem_wr_o,
   output logic [XLEN-1:0]    mem_addr_o,
   output logic [XLEN-1:0]    mem_wdata_o,
   output logic [BE_W-1:0]    mem_be_o,
   output logic [XLEN-1:0]    alu_res_o,
   output logic [RADDR_W-1:0] rd_addr_o,
   output logic               misalign_o
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("exmem_stage_reg: XLEN must be 32 or 64");
   end

   logic [XLEN-1:0] ea;
   logic [XLEN-1:0] wdata;
   logic [BE_W-1:0] be;
   logic            misalign;
   logic            take;

   agu_align #(
      .XLEN (XLEN)
   ) u_agu (
      .addr_mode (addr_mode_i),
      .size      (size_i),
      .mem_rd    (mem_rd_i),
      .mem_wr    (mem_wr_i),
      .imm       (imm_i),
      .rs1       (rs1_data_i),
      .rs2       (rs2_data_i),
      .ea        (ea),
      .wdata     (wdata),
      .be        (be),
      .misalign  (misalign)
   );

   assign ready_o = !valid_o || ready_i;
   assign take    = valid_i && ready_o;

   // Flush only clears the qualifying bits; data fields may stay stale.
   // A bad access is still captured as valid so the exception path sees it,
   // with its side-effecting controls suppressed.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         valid_o     <= 1'b0;
         wb_o        <= 1'b0;
         mem_rd_o    <= 1'b0;
         mem_wr_o    <= 1'b0;
         misalign_o  <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_be_o    <= '0;
         alu_res_o   <= '0;
         rd_addr_o   <= '0;
      end else if (flush_i) begin
         valid_o    <= 1'b0;
         wb_o       <= 1'b0;
         mem_rd_o   <= 1'b0;
         mem_wr_o   <= 1'b0;
         misalign_o <= 1'b0;
      end else if (take) begin
         valid_o     <= 1'b1;
         wb_o        <= wb_i && !misalign;
         mem_rd_o    <= mem_rd_i && !misalign;
         mem_wr_o    <= mem_wr_i && !misalign;
         misalign_o  <= misalign;
         mem_addr_o  <= ea;
         mem_wdata_o <= wdata;
         mem_be_o    <= be;
         alu_res_o   <= alu_res_i;
         rd_addr_o   <= rd_addr_i;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exmem_stage_reg.sv
module tb_exmem_stage_reg;

   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;
   localparam int BE_W    = XLEN / 8;

   localparam int PH_RESET   = 0;
   localparam int PH_VALID   = 1;
   localparam int PH_FLUSHED = 2;
   localparam int PH_RETIRED = 3;

   logic               clk_i = 1'b0;
   logic               rst_n_i = 1'b0;
   logic               valid_i = 1'b0;
   logic               ready_o;
   logic               flush_i = 1'b0;
   logic               wb_i = 1'b0;
   logic               mem_rd_i = 1'b0;
   logic               mem_wr_i = 1'b0;
   logic               addr_mode_i = 1'b0;
   logic [1:0]         size_i = 2'b00;
   logic [XLEN-1:0]    alu_res_i = '0;
   logic [XLEN-1:0]    imm_i = '0;
   logic [XLEN-1:0]    rs1_data_i = '0;
   logic [XLEN-1:0]    rs2_data_i = '0;
   logic [RADDR_W-1:0] rd_addr_i = '0;
   logic               valid_o;
   logic               ready_i = 1'b1;
   logic               wb_o;
   logic               mem_rd_o;
   logic               mem_wr_o;
   logic [XLEN-1:0]    mem_addr_o;
   logic [XLEN-1:0]    mem_wdata_o;
   logic [BE_W-1:0]    mem_be_o;
   logic [XLEN-1:0]    alu_res_o;
   logic [RADDR_W-1:0] rd_addr_o;
   logic               misalign_o;

   int n_checks = 0;
   int n_errors = 0;

   // reference model of the stage contents
   int                 m_phase = PH_RESET;
   logic               m_valid = 1'b0;
   logic               m_wb = 1'b0, m_rd = 1'b0, m_wr = 1'b0, m_mis = 1'b0;
   logic [XLEN-1:0]    m_addr = '0, m_wdata = '0, m_alu = '0;
   logic [BE_W-1:0]    m_be = '0;
   logic [RADDR_W-1:0] m_rd_addr = '0;

   exmem_stage_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .flush_i     (flush_i),
      .wb_i        (wb_i),
      .mem_rd_i    (mem_rd_i),
      .mem_wr_i    (mem_wr_i),
      .addr_mode_i (addr_mode_i),
      .size_i      (size_i),
      .alu_res_i   (alu_res_i),
      .imm_i       (imm_i),
      .rs1_data_i  (rs1_data_i),
      .rs2_data_i  (rs2_data_i),
      .rd_addr_i   (rd_addr_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .wb_o        (wb_o),
      .mem_rd_o    (mem_rd_o),
      .mem_wr_o    (mem_wr_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_be_o    (mem_be_o),
      .alu_res_o   (alu_res_o),
      .rd_addr_o   (rd_addr_o),
      .misalign_o  (misalign_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected entry for the presented instruction, from the access rules.
   task automatic model_capture();
      logic [XLEN-1:0] ea;
      int   bytes, off, lanes;
      logic mem_op, bad;
      ea     = rs1_data_i + (addr_mode_i ? rs2_data_i : imm_i);
      bytes  = 1 << size_i;
      off    = int'(ea % BE_W);
      mem_op = mem_rd_i || mem_wr_i;
      bad    = (bytes > BE_W) || (ea % bytes != 0) || (mem_rd_i && mem_wr_i);
      lanes  = ((1 << bytes) - 1) << off;
      m_valid   = 1'b1;
      m_mis     = mem_op && bad;
      m_wb      = wb_i && !m_mis;
      m_rd      = mem_rd_i && !m_mis;
      m_wr      = mem_wr_i && !m_mis;
      m_addr    = ea;
      m_wdata   = XLEN'(64'(rs2_data_i) << (8 * off));
      m_be      = (mem_op && !bad) ? BE_W'(lanes) : '0;
      m_alu     = alu_res_i;
      m_rd_addr = rd_addr_i;
      m_phase   = PH_VALID;
   endtask

   task automatic check_all();
      chk("valid_o", valid_o, m_valid);
      if (m_phase != PH_RETIRED) begin
         chk("wb_o", wb_o, m_wb);
         chk("mem_rd_o", mem_rd_o, m_rd);
         chk("mem_wr_o", mem_wr_o, m_wr);
      end
      if (m_phase == PH_RESET || m_phase == PH_VALID) begin
         chk("misalign_o", misalign_o, m_mis);
         chk("mem_addr_o", mem_addr_o, m_addr);
         chk("mem_wdata_o", mem_wdata_o, m_wdata);
         chk("mem_be_o", mem_be_o, m_be);
         chk("alu_res_o", alu_res_o, m_alu);
         chk("rd_addr_o", rd_addr_o, m_rd_addr);
      end
   endtask

   // One clock: check ready_o, step the model across the edge, check outputs.
   task automatic tick();
      #1;
      chk("ready_o", ready_o, !m_valid || ready_i);
      if (!rst_n_i) begin
         m_valid = 0; m_wb = 0; m_rd = 0; m_wr = 0; m_mis = 0;
         m_addr = '0; m_wdata = '0; m_be = '0; m_alu = '0; m_rd_addr = '0;
         m_phase = PH_RESET;
      end else if (flush_i) begin
         m_valid = 0; m_wb = 0; m_rd = 0; m_wr = 0;
         m_phase = PH_FLUSHED;
      end else if (valid_i && (!m_valid || ready_i)) begin
         model_capture();
      end else if (m_valid && ready_i) begin
         m_valid = 0;
         m_phase = PH_RETIRED;
      end
      @(posedge clk_i);
      #1;
      check_all();
   endtask

   task automatic set_instr(input logic wb, input logic rd, input logic wr, input logic mode,
                            input logic [1:0] size, input logic [XLEN-1:0] rs1,
                            input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] imm);
      valid_i     = 1'b1;
      wb_i        = wb;
      mem_rd_i    = rd;
      mem_wr_i    = wr;
      addr_mode_i = mode;
      size_i      = size;
      rs1_data_i  = rs1;
      rs2_data_i  = rs2;
      imm_i       = imm;
      alu_res_i   = $urandom;
      rd_addr_i   = RADDR_W'($urandom);
   endtask

   initial begin
      // reset
      rst_n_i = 1'b0; valid_i = 1'b1; flush_i = 1'b1;
      tick();
      tick();
      chk("reset_valid", valid_o, 1'b0);
      chk("reset_be", mem_be_o, 0);
      rst_n_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0;
      tick();

      // word store, rs1+imm
      ready_i = 1'b1;
      set_instr(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h1000, 32'hDEADBEEF, 32'h8);
      tick();
      chk("st_word_addr", mem_addr_o, 32'h1008);
      chk("st_word_be", mem_be_o, 4'hF);
      chk("st_word_wdata", mem_wdata_o, 32'hDEADBEEF);
      chk("st_word_mis", misalign_o, 1'b0);

      // byte store, rs1+rs2
      set_instr(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h2000, 32'h3, 32'h0);
      tick();
      chk("st_byte_addr", mem_addr_o, 32'h2003);
      chk("st_byte_be", mem_be_o, 4'h8);
      chk("st_byte_wdata", mem_wdata_o, 32'h03000000);

      // misaligned half load
      set_instr(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 32'h1000, 32'h0, 32'h1);
      tick();
      chk("mis_half_flag", misalign_o, 1'b1);
      chk("mis_half_rd", mem_rd_o, 1'b0);
      chk("mis_half_wb", wb_o, 1'b0);
      chk("mis_half_be", mem_be_o, 0);
      chk("mis_half_valid", valid_o, 1'b1);

      // stall: A captured, B presented for three held cycles
      set_instr(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h4000, 32'h0, 32'h10);
      tick();
      set_instr(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h5000, 32'h1234, 32'h2);
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ready", ready_o, 1'b0);
         chk("stall_addr_a", mem_addr_o, 32'h4010);
      end
      ready_i = 1'b1;
      tick();
      chk("stall_addr_b", mem_addr_o, 32'h5002);
      chk("stall_be_b", mem_be_o, 4'hC);

      // flush against a simultaneous capture
      set_instr(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h6000, 32'h55, 32'h0);
      flush_i = 1'b1;
      tick();
      chk("flush_valid", valid_o, 1'b0);
      chk("flush_wb", wb_o, 1'b0);
      chk("flush_wr", mem_wr_o, 1'b0);
      flush_i = 1'b0;

      // wrap-around word load
      set_instr(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'hFFFFFFFC, 32'h0, 32'h8);
      tick();
      chk("wrap_addr", mem_addr_o, 32'h4);
      chk("wrap_mis", misalign_o, 1'b0);

      // dword and load+store are illegal on a 32-bit datapath
      set_instr(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 32'h8000, 32'h0, 32'h0);
      tick();
      chk("dword_mis", misalign_o, 1'b1);
      set_instr(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h8000, 32'h0, 32'h1);
      tick();
      chk("rdwr_mis", misalign_o, 1'b1);
      // non-memory op with odd address and dword size
      set_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 32'h8001, 32'h0, 32'h0);
      tick();
      chk("nonmem_mis", misalign_o, 1'b0);
      chk("nonmem_wb", wb_o, 1'b1);

      // reset while holding a valid entry
      set_instr(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h9000, 32'h0, 32'h4);
      tick();
      ready_i = 1'b0;
      rst_n_i = 1'b0;
      tick();
      chk("rst_hold_valid", valid_o, 1'b0);
      chk("rst_hold_addr", mem_addr_o, 0);
      chk("rst_hold_wb", wb_o, 1'b0);
      rst_n_i = 1'b1;

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [XLEN-1:0] rs1, rs2, imm;
         rs1 = $urandom;
         rs2 = $urandom;
         imm = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            rs1 = rs1 & ~32'h7;
            imm = imm & 32'h7;
            rs2 = rs2 & 32'hFFFF_FFF3;
         end
         set_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   2'($urandom), rs1, rs2, imm);
         valid_i = ($urandom_range(0, 3) != 0);
         ready_i = ($urandom_range(0, 9) < 7);
         flush_i = ($urandom_range(0, 9) == 0);
         rst_n_i = ($urandom_range(0, 49) != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
